// File: rtl/m68k_bus_target.sv
// 68000 bus responder: decodes a cycle against a base window and serves a small
// register file (ID word, hit counter, RW words) with programmable wait states.
module m68k_bus_target #(
    parameter logic [23:0] BASE_ADDR   = 24'hE80000,
    parameter int          ADDR_BITS   = 4,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] ID_VALUE    = 16'h68A5,
    parameter bit          BERR_ON_RO  = 1'b1,
    parameter logic [15:0] HIT_PRELOAD = 16'h0000
) (
    input  logic        M68K_CLK,
    input  logic        M68K_RESET_n,
    input  logic [23:1] M68K_A,
    input  logic [2:0]  M68K_FC,
    input  logic        M68K_AS_n,
    input  logic        M68K_UDS_n,
    input  logic        M68K_LDS_n,
    input  logic        M68K_RW,
    input  logic [15:0] M68K_D_IN,
    output logic [15:0] M68K_D_OUT,
    output logic        M68K_D_OE,
    output logic        M68K_DTACK_n,
    output logic        M68K_BERR_n,
    output logic [15:0] HIT_COUNT
);

    localparam int NUM_WORDS = 1 << ADDR_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_ACK,
        ST_ERR,
        ST_IGNORE
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             as_sync_q, uds_sync_q, lds_sync_q;
    logic [3:0]             wait_cnt_q, wait_cnt_d;
    logic [ADDR_BITS-1:0]   offset_q, offset_d;
    logic                   rw_q, rw_d;
    logic                   uds_q, uds_d;
    logic                   lds_q, lds_d;
    logic                   hit_q, hit_d;
    logic                   dtack_n_q, dtack_n_d;
    logic                   berr_n_q, berr_n_d;
    logic                   d_oe_q, d_oe_d;
    logic [15:0]            d_out_q, d_out_d;
    logic [15:0]            hit_count_q, hit_count_d;
    logic [15:0]            regs_q [NUM_WORDS];

    logic                   as_s, uds_s, lds_s;
    logic [ADDR_BITS-1:0]   a_off;
    logic                   addr_match;
    logic                   offset_ro;
    logic [15:0]            rd_word;
    logic                   enter_ack;
    logic                   wr_en;

    assign as_s       = as_sync_q[1];
    assign uds_s      = uds_sync_q[1];
    assign lds_s      = lds_sync_q[1];
    assign a_off      = M68K_A[ADDR_BITS:1];
    assign addr_match = (M68K_A[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1]);
    assign offset_ro  = (offset_q[ADDR_BITS-1:1] == '0);

    // Strobes are asynchronous to our clock; everything else is stable while AS is low.
    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            as_sync_q  <= 2'b11;
            uds_sync_q <= 2'b11;
            lds_sync_q <= 2'b11;
        end else begin
            as_sync_q  <= {as_sync_q[0], M68K_AS_n};
            uds_sync_q <= {uds_sync_q[0], M68K_UDS_n};
            lds_sync_q <= {lds_sync_q[0], M68K_LDS_n};
        end
    end

    always_comb begin
        rd_word = regs_q[a_off];
        if (a_off == '0) begin
            rd_word = ID_VALUE;
        end else if (a_off == ADDR_BITS'(1)) begin
            rd_word = hit_count_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        offset_d    = offset_q;
        rw_d        = rw_q;
        uds_d       = uds_q;
        lds_d       = lds_q;
        hit_d       = hit_q;
        dtack_n_d   = dtack_n_q;
        berr_n_d    = berr_n_q;
        d_oe_d      = d_oe_q;
        d_out_d     = d_out_q;
        hit_count_d = hit_count_q;
        enter_ack   = 1'b0;
        wr_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!as_s && (!uds_s || !lds_s)) begin
                    state_d  = ST_DECODE;
                    offset_d = a_off;
                    rw_d     = M68K_RW;
                    uds_d    = !uds_s;
                    lds_d    = !lds_s;
                    hit_d    = addr_match && (M68K_FC != 3'b111);
                    if (addr_match && (M68K_FC != 3'b111) && M68K_RW) begin
                        d_out_d = rd_word;
                        d_oe_d  = 1'b1;
                    end
                end
            end
            ST_DECODE: begin
                if (as_s) begin
                    state_d = ST_IDLE;
                    d_oe_d  = 1'b0;
                end else if (!hit_q) begin
                    state_d = ST_IGNORE;
                end else if (!rw_q && offset_ro && BERR_ON_RO) begin
                    state_d  = ST_ERR;
                    berr_n_d = 1'b0;
                end else if (WAIT_STATES == 0) begin
                    enter_ack = 1'b1;
                end else begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 4'(WAIT_STATES - 1);
                end
            end
            ST_WAIT: begin
                if (as_s) begin
                    state_d = ST_IDLE;
                    d_oe_d  = 1'b0;
                end else if (wait_cnt_q == 4'd0) begin
                    enter_ack = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                if (as_s) begin
                    state_d   = ST_IDLE;
                    dtack_n_d = 1'b1;
                    d_oe_d    = 1'b0;
                end
            end
            ST_ERR: begin
                if (as_s) begin
                    state_d  = ST_IDLE;
                    berr_n_d = 1'b1;
                end
            end
            ST_IGNORE: begin
                if (as_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Side effects happen exactly once, on the edge that enters ACK.
        if (enter_ack) begin
            state_d     = ST_ACK;
            dtack_n_d   = 1'b0;
            hit_count_d = hit_count_q + 16'd1;
            wr_en       = !rw_q && !offset_ro;
        end
    end

    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 4'd0;
            offset_q    <= '0;
            rw_q        <= 1'b1;
            uds_q       <= 1'b0;
            lds_q       <= 1'b0;
            hit_q       <= 1'b0;
            dtack_n_q   <= 1'b1;
            berr_n_q    <= 1'b1;
            d_oe_q      <= 1'b0;
            d_out_q     <= 16'h0000;
            hit_count_q <= HIT_PRELOAD;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            offset_q    <= offset_d;
            rw_q        <= rw_d;
            uds_q       <= uds_d;
            lds_q       <= lds_d;
            hit_q       <= hit_d;
            dtack_n_q   <= dtack_n_d;
            berr_n_q    <= berr_n_d;
            d_oe_q      <= d_oe_d;
            d_out_q     <= d_out_d;
            hit_count_q <= hit_count_d;
        end
    end

    always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
        if (!M68K_RESET_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                regs_q[i] <= 16'h0000;
            end
        end else if (wr_en) begin
            if (uds_q) begin
                regs_q[offset_q][15:8] <= M68K_D_IN[15:8];
            end
            if (lds_q) begin
                regs_q[offset_q][7:0] <= M68K_D_IN[7:0];
            end
        end
    end

    assign M68K_D_OUT   = d_out_q;
    assign M68K_D_OE    = d_oe_q;
    assign M68K_DTACK_n = dtack_n_q;
    assign M68K_BERR_n  = berr_n_q;
    assign HIT_COUNT    = hit_count_q;

endmodule
